// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MULL = 2'b00,
    MULH = 2'b01,
    DIVU = 2'b10,
    REMU = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Divide-class ops share bit 1 of the opcode.
  function automatic logic is_div(op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/writeback bundle between control, register file and the multiply/divide unit.
interface mul_div_unit_if #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 3
);
  import mdu_pkg::*;

  logic         start;
  op_t          op;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic [D-1:0] dest;
  logic         busy;
  logic         done;
  logic         write_en;
  logic [D-1:0] waddr;
  logic [W-1:0] data_out;
  logic         div0;

  modport master (
    output start, op, opA, opB, dest,
    input  busy, done, write_en, waddr, data_out, div0
  );

  modport slave (
    input  start, op, opA, opB, dest,
    output busy, done, write_en, waddr, data_out, div0
  );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply / divide: W iterations, then a one-cycle register-file writeback.
// Multiply and divide share one {hi,lo} register pair: for multiply it holds the growing
// product, for divide hi is the partial remainder and lo the dividend/quotient shift register.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned D = 3
) (
  input  logic           CLK,
  input  logic           Reset,
  mul_div_unit_if.slave  bus_io
);

  localparam int unsigned CW = $clog2(W) + 1;

  state_t         state_q, state_d;
  op_t            op_q, op_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [D-1:0]   dest_q, dest_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [D-1:0]   waddr_q, waddr_d;
  logic [W-1:0]   data_q, data_d;
  logic           div0_q, div0_d;

  logic [W:0]     mul_sum;
  logic [W:0]     rem_shift;
  logic [W:0]     rem_trial;
  logic [W-1:0]   hi_nx;
  logic [W-1:0]   lo_nx;

  // One shift-add (multiply) or restoring-subtract (divide) step of the shared datapath.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : {(W + 1){1'b0}});
    rem_shift = {hi_q, lo_q[W-1]};
    rem_trial = rem_shift - {1'b0, opb_q};
    if (is_div(op_q)) begin
      // Borrow out of the trial subtraction means the divisor did not fit: restore.
      if (!rem_trial[W]) begin
        hi_nx = rem_trial[W-1:0];
        lo_nx = {lo_q[W-2:0], 1'b1};
      end else begin
        hi_nx = rem_shift[W-1:0];
        lo_nx = {lo_q[W-2:0], 1'b0};
      end
    end else begin
      hi_nx = mul_sum[W:1];
      lo_nx = {mul_sum[0], lo_q[W-1:1]};
    end
  end

  // Next-state logic: operand capture, iteration sequencing and result latching.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    dest_d  = dest_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    waddr_d = waddr_q;
    data_d  = data_q;
    div0_d  = div0_q;
    case (state_q)
      IDLE: begin
        if (bus_io.start) begin
          state_d = RUN;
          op_d    = bus_io.op;
          opa_d   = bus_io.opA;
          opb_d   = bus_io.opB;
          dest_d  = bus_io.dest;
          cnt_d   = '0;
          hi_d    = '0;
          // Divide shifts the dividend out of lo; multiply shifts the multiplier out.
          lo_d    = is_div(bus_io.op) ? bus_io.opA : bus_io.opB;
        end
      end
      RUN: begin
        hi_d  = hi_nx;
        lo_d  = lo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
          waddr_d = dest_q;
          // hi ends as product high half / remainder, lo as product low half / quotient.
          data_d  = (op_q == MULH || op_q == REMU) ? hi_nx : lo_nx;
          div0_d  = is_div(op_q) && (opb_q == '0);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      op_q    <= MULL;
      opa_q   <= '0;
      opb_q   <= '0;
      dest_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      waddr_q <= '0;
      data_q  <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      dest_q  <= dest_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      div0_q  <= div0_d;
    end
  end

  assign bus_io.busy     = (state_q != IDLE);
  assign bus_io.done     = (state_q == DONE);
  assign bus_io.write_en = (state_q == DONE);
  assign bus_io.waddr    = waddr_q;
  assign bus_io.data_out = data_q;
  assign bus_io.div0     = div0_q && (state_q == DONE);

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative unsigned multiply/divide unit for the 8-bit datapath. It takes the two register-file read operands (port A and port B values) plus a destination pointer. Over W cycles it computes a product or a quotient/remainder, then issues a single-cycle writeback (write_en, waddr, data) back into the register file's write port. While it runs it raises busy so control stalls issue.

Parameters:
W, 8, data path width (operand and result width)
D, 3, register pointer width
CW, $clog2(W)+1, iteration counter width (derived, not overridden)

Ports:
CLK  input  1  clock; all state changes on rising edge
Reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  00 MULL, 01 MULH, 10 DIVU quotient, 11 REMU remainder
opA  input  W  multiplicand / dividend (register read port A value)
opB  input  W  multiplier / divisor (register read port B value)
dest  input  D  destination register pointer
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, result valid
write_en  output  1  register-file write enable, equals done
waddr  output  D  latched dest, valid with done
data_out  output  W  result, valid with done, held until next done
div0  output  1  high with done when a DIV/REM op had opB == 0

Behaviour:
- Reset value of every output is 0: busy, done, write_en, waddr, data_out, div0. State resets to IDLE and counter to 0. Reset is asynchronous and acts mid-operation: any in-flight result is discarded and no write_en is issued.
- States are IDLE, RUN, DONE.
- IDLE:
  - On start=1 at edge k, latch op, opA, opB, dest; clear the accumulator and counter; go to RUN.
  - start=0 stays in IDLE.
- RUN:
  - Each edge performs one iteration and increments the counter.
  - After the W-th iteration (edge k+W), go to DONE.
- DONE:
  - done = write_en = 1 for exactly one cycle (the cycle after edge k+W). waddr = latched dest; data_out = selected result.
  - Unconditionally return to IDLE next edge.
- Latency: start sampled at edge k gives write_en high during the cycle following edge k+W (W+1 cycles). Back-to-back throughput is one op per W+2 cycles.
- start while busy (RUN or DONE) is ignored and not queued. Operand inputs are don't-care outside the start edge.
- Multiply:
  - Unsigned shift-add; 2W-bit product built in a {hi,lo} accumulator.
  - MULL returns product[W-1:0]; MULH returns product[2W-1:W]. No overflow flag.
- Divide:
  - Unsigned restoring division, one quotient bit per iteration, MSB first; W+1-bit partial remainder.
  - DIVU returns the quotient; REMU returns the remainder.
- Divide by zero:
  - Still W iterations, no early exit. The natural restoring result is required: quotient = all ones (0xFF), remainder = opA. div0=1 with done.
  - div0 is 0 for MUL ops and for nonzero divisors.
- dest == 0: write_en still pulses. The register file discards writes to pointer 0; the unit does not special-case it.
- data_out and waddr hold their last values after done until the next DONE or Reset.

Decomposition:
- Package mdu_pkg:
  - typedef enum logic [1:0] op_t {MULL, MULH, DIVU, REMU}
  - typedef enum logic [1:0] state_t {IDLE, RUN, DONE}
- Single module, no sub-module. The datapath (accumulator, partial remainder, quotient shift register) is small enough to stay inline with the FSM.

Test Plan:
- MULL 13*11: opA=0x0D, opB=0x0B, dest=3 -> write_en exactly 9 cycles after the start edge, waddr=3, data_out=0x8F, div0=0.
- MULH/MULL 200*200: opA=opB=0xC8 -> MULH data_out=0x9C; MULL data_out=0x40.
- DIVU/REMU 200/7: opA=0xC8, opB=0x07 -> DIVU 0x1C; REMU 0x04; div0=0.
- Divide by zero: opA=0x5A, opB=0x00 -> DIVU 0xFF with div0=1; REMU 0x5A with div0=1; same 9-cycle latency.
- start pulsed during RUN with different operands -> ignored; only the first result is written, exactly one write_en pulse; busy stays high until back in IDLE.
- Reset asserted asynchronously 4 cycles into RUN -> busy, done, write_en, data_out go 0 immediately with no write_en pulse; a fresh start afterwards gives a correct result with full latency.
